vc_arbiter: RTL
===============

# vc_arbiter

Parametrised virtual-channel arbiter for the PCIe link layer. It grants one of `NUM_VC` requesting channels at a time. The top `NUM_STRICT` channels are served by strict priority, and the remaining channels by credit-weighted round-robin with a starvation guard. A grant is held until the served channel signals `done`. The arbiter sits between the per-VC transmit queues and the shared link transmitter.

## Interface
- `NUM_VC`, 8: total channels, 2..16.
- `NUM_STRICT`, 3: number of top-index channels under strict priority, 0..NUM_VC-1.
- `WEIGHT_W`, 4: width of each per-channel weight and credit counter.
- `STARVE_LIMIT`, 4: maximum consecutive strict grants while a WRR request is pending; 0 disables the guard.
- `clk` in 1: clock.
- `clr` in 1: reset, asynchronous, active-low.
- `req` in NUM_VC: request per channel, level-sensitive.
- `weight` in NUM_VC*WEIGHT_W: per-channel WRR weight; channel i uses bits [i*WEIGHT_W +: WEIGHT_W]; strict channels ignore it.
- `done` in 1: single-cycle pulse from the served channel; releases the current grant.
- `grant` out NUM_VC: one-hot grant, registered.
- `grant_valid` out 1: high while any grant is held.
- `grant_id` out clog2(NUM_VC): binary index of the held grant; 0 when idle.

## Operation
- NUM_WRR = NUM_VC - NUM_STRICT. Channels 0..NUM_WRR-1 are WRR; NUM_WRR..NUM_VC-1 are strict.
- FSM states: REFILL, ARB, GRANT.
- REFILL (1 cycle):
  - Load each WRR credit counter from its `weight`.
  - Go to ARB.
- ARB, no `req` asserted: stay in ARB.
- ARB, priority order when requests are present:
  1. Guard tripped: if `STARVE_LIMIT` != 0, the starve counter equals `STARVE_LIMIT`, and an eligible WRR request exists, serve WRR.
  2. Otherwise, if any strict channel is requesting, grant the highest-index strict requester and increment the starve counter, but only if a WRR request is pending.
  3. Otherwise, serve WRR.
- WRR service:
  - Eligible means `req[i]` is high and `credit[i]` > 0.
  - Search ascending from `ptr+1` and wrap at NUM_WRR.
  - Grant the first eligible channel, decrement its credit, set `ptr` to that index, and clear the starve counter.
- WRR requesters present but none eligible: go to REFILL with no grant. Strict requests are still served first, because rule 2 precedes this check.
- Any WRR grant clears the starve counter. The starve counter saturates at `STARVE_LIMIT`.
- Weight 0 means the channel is disabled. It is never granted, and a request from it alone does not trigger REFILL.
- GRANT:
  - `grant`, `grant_id` and `grant_valid` hold until `done` is sampled high, then return to ARB.
  - Deassertion of `req` by the held channel is ignored.
  - `done` in any state other than GRANT is ignored.
- `weight` is sampled only in REFILL. Changes take effect at the next refill.

## Timing
- Reset values: state=REFILL, `grant`=0, `grant_valid`=0, `grant_id`=0, all credits=0, `ptr`=NUM_WRR-1, starve counter=0.
- First cycle after `clr` release: REFILL. Earliest grant is on the 2nd edge after release.
- Request latency: `req` sampled in ARB at edge n gives `grant` visible after edge n (registered outputs).
- `done` at edge m clears `grant` after edge m. The next grant appears after edge m+1, so there is one dead cycle between grants.
- REFILL adds one extra cycle before the next WRR grant.
- If `done` arrives in the same cycle as new requests, the new requests are evaluated in the following ARB cycle.
- Reset mid-grant:
  - Outputs clear asynchronously.
  - Credits, `ptr` and the starve counter reinitialise.
  - There is no partial handshake state.

## Structure
- Shared package `vc_arb_pkg`:
  - FSM state encoding (REFILL/ARB/GRANT).
  - Function `onehot2bin`.
  - Default parameter constants.
- Sub-module `rr_pick`:
  - Parametrised rotating priority picker.
  - Inputs: eligible vector and `ptr`. Outputs: one-hot pick and a found flag.
  - Purely combinational; instantiated once for the WRR group.
- Strict priority selection, credit counters, starve counter and FSM live in `vc_arbiter`.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles: `grant`=0 and `grant_valid`=0 throughout; state passes REFILL and then stays in ARB.
- `req`=8'hE0 with `done` pulsed every grant: grants go to 7, 7, 7…, and `grant_id`=7 each time. After dropping `req[7]`, grants go to 6.
- NUM_STRICT=3, all weights=2, `req`=8'h1F held, `done` each grant:
  - Grant order is 0,1,2,3,4,0,1,2,3,4.
  - Then one REFILL cycle without a grant, then the order repeats.
- Weights {4:1, 0:3}, `req`=8'h11: order is 0,4,0,0, then REFILL.
- STARVE_LIMIT=4, `req`=8'h81 held:
  - Grants go 7,7,7,7,0,7,7,7,7,0…
  - With STARVE_LIMIT=0, only channel 7 is ever granted.
- `clr` low while `grant`=8'h04 is held: `grant`, `grant_valid` and `grant_id` go to 0 immediately. After release, the first WRR grant goes to channel 0.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared definitions for the virtual-channel arbiter: FSM encoding, defaults, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vc_arb_pkg;

  localparam int DEF_NUM_VC       = 8;
  localparam int DEF_NUM_STRICT   = 3;
  localparam int DEF_WEIGHT_W     = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  // Widest one-hot vector the index helper understands (NUM_VC tops out at 16).
  localparam int OH_MAX = 16;

  localparam logic [1:0] ST_REFILL = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;

  // Binary index of a one-hot vector; callers zero-extend to OH_MAX and truncate the result.
  function automatic int unsigned onehot2bin(input logic [OH_MAX-1:0] oh);
    int unsigned b;
    b = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) b = b | int'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first eligible entry searching upward from ptr+1, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the pick is only a candidate, the caller decides whether to take it.
module rr_pick
  import vc_arb_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic          o_found
);

  // Walk the N positions after the pointer; the pointer itself is visited last.
  always_comb begin
    int idx;
    idx     = 0;
    o_pick  = '0;
    o_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_found && i_elig[idx]) begin
        o_pick[idx] = 1'b1;
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Virtual-channel arbiter: strict priority for top channels, credit-weighted RR with starvation guard below.
// Latency: grant registered one edge after the deciding ARB cycle; one dead cycle between grants.
// Backpressure: a grant is held until done; requests arriving meanwhile wait for the next ARB cycle.
module vc_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_VC       = DEF_NUM_VC,
  parameter int NUM_STRICT   = DEF_NUM_STRICT,
  parameter int WEIGHT_W     = DEF_WEIGHT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NUM_VC-1:0]            i_req,
  input  logic [NUM_VC*WEIGHT_W-1:0]   i_weight,
  input  logic                         i_done,
  output logic [NUM_VC-1:0]            o_grant,
  output logic                         o_grant_valid,
  output logic [$clog2(NUM_VC)-1:0]    o_grant_id
);

  localparam int NUM_WRR = NUM_VC - NUM_STRICT;
  localparam int PTR_W   = (NUM_WRR > 1) ? $clog2(NUM_WRR) : 1;
  localparam int SC_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int ID_W    = $clog2(NUM_VC);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_WRR - 1);

  logic [1:0]          r_state;
  logic [WEIGHT_W-1:0] r_credit [NUM_WRR];
  logic [NUM_WRR-1:0]  r_en;
  logic [PTR_W-1:0]    r_ptr;
  logic [SC_W-1:0]     r_starve;
  logic [NUM_VC-1:0]   r_grant;
  logic                r_grant_vld;
  logic [ID_W-1:0]     r_grant_id;

  logic [NUM_WRR-1:0]  w_wrr_live;
  logic [NUM_WRR-1:0]  w_wrr_elig;
  logic [NUM_WRR-1:0]  w_wrr_pick;
  logic                w_wrr_found;
  logic [NUM_VC-1:0]   w_wrr_full;
  logic [NUM_VC-1:0]   w_strict_pick;
  logic                w_strict_any;
  logic                w_guard;
  logic                w_take_wrr;
  logic                w_take_strict;
  logic                w_go_refill;
  logic [NUM_VC-1:0]   w_next_grant;
  logic [ID_W-1:0]     w_next_id;
  logic [PTR_W-1:0]    w_pick_bin;
  logic [OH_MAX-1:0]   w_grant_oh;
  logic [OH_MAX-1:0]   w_pick_oh;

  // Strict channels carry weight bits that are never consulted.
  generate
    if (NUM_STRICT > 0) begin : g_strict_weight
      logic w_unused_weight;
      assign w_unused_weight = ^i_weight[NUM_VC*WEIGHT_W-1:NUM_WRR*WEIGHT_W];
    end
  endgenerate

  // WRR request classification: live = requesting and enabled, eligible = requesting with credit left.
  always_comb begin
    w_wrr_live = '0;
    w_wrr_elig = '0;
    for (int i = 0; i < NUM_WRR; i++) begin
      w_wrr_live[i] = i_req[i] & r_en[i];
      w_wrr_elig[i] = i_req[i] & (r_credit[i] != '0);
    end
  end

  rr_pick #(
    .N  (NUM_WRR),
    .PW (PTR_W)
  ) u_rr_pick (
    .i_elig  (w_wrr_elig),
    .i_ptr   (r_ptr),
    .o_pick  (w_wrr_pick),
    .o_found (w_wrr_found)
  );

  // Highest-index requesting strict channel wins.
  always_comb begin
    w_strict_pick = '0;
    w_strict_any  = 1'b0;
    for (int i = NUM_VC - 1; i >= NUM_WRR; i--) begin
      if (!w_strict_any && i_req[i]) begin
        w_strict_pick[i] = 1'b1;
        w_strict_any     = 1'b1;
      end
    end
  end

  // Service decision: tripped guard, then strict, then WRR, then refill only for enabled WRR requesters.
  always_comb begin
    w_guard       = (STARVE_LIMIT != 0) && (r_starve == SC_MAX) && w_wrr_found;
    w_take_wrr    = 1'b0;
    w_take_strict = 1'b0;
    w_go_refill   = 1'b0;
    if (w_guard)           w_take_wrr    = 1'b1;
    else if (w_strict_any) w_take_strict = 1'b1;
    else if (w_wrr_found)  w_take_wrr    = 1'b1;
    else if (|w_wrr_live)  w_go_refill   = 1'b1;
  end

  // Candidate grant vector and its binary forms for grant_id and the RR pointer.
  always_comb begin
    w_wrr_full                = '0;
    w_wrr_full[NUM_WRR-1:0]   = w_wrr_pick;
    w_next_grant              = w_take_wrr ? w_wrr_full : w_strict_pick;
    w_grant_oh                = '0;
    w_grant_oh[NUM_VC-1:0]    = w_next_grant;
    w_pick_oh                 = '0;
    w_pick_oh[NUM_WRR-1:0]    = w_wrr_pick;
    w_next_id                 = ID_W'(onehot2bin(w_grant_oh));
    w_pick_bin                = PTR_W'(onehot2bin(w_pick_oh));
  end

  // FSM with credits, pointer, starve counter and registered grant outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= ST_REFILL;
      r_en        <= '0;
      r_ptr       <= PTR_RST;
      r_starve    <= '0;
      r_grant     <= '0;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      for (int i = 0; i < NUM_WRR; i++) r_credit[i] <= '0;
    end else begin
      case (r_state)
        ST_REFILL: begin
          for (int i = 0; i < NUM_WRR; i++) begin
            r_credit[i] <= i_weight[i*WEIGHT_W +: WEIGHT_W];
            r_en[i]     <= |i_weight[i*WEIGHT_W +: WEIGHT_W];
          end
          r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_take_wrr || w_take_strict) begin
            r_grant     <= w_next_grant;
            r_grant_vld <= 1'b1;
            r_grant_id  <= w_next_id;
            r_state     <= ST_GRANT;
            if (w_take_wrr) begin
              for (int i = 0; i < NUM_WRR; i++) begin
                if (w_wrr_pick[i]) r_credit[i] <= r_credit[i] - 1'b1;
              end
              r_ptr    <= w_pick_bin;
              r_starve <= '0;
            end else if ((|w_wrr_live) && (r_starve != SC_MAX)) begin
              r_starve <= r_starve + 1'b1;
            end
          end else if (w_go_refill) begin
            r_state <= ST_REFILL;
          end
        end
        ST_GRANT: begin
          if (i_done) begin
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_state     <= ST_ARB;
          end
        end
        default: r_state <= ST_REFILL;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_vld;
  assign o_grant_id    = r_grant_id;

endmodule
